regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor of the single-cycle integer register file, intended for the pipelined RISC-V core.
- Provides a configurable-width and configurable-depth register array with two asynchronous read ports and one write port.
- Register 0 is hardwired to zero.
- Adds an optional write-to-read bypass, a per-register busy scoreboard for hazard detection, and a sequential clear engine that scrubs the array to zero without asserting reset.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREGS, 32, number of architectural registers; must be a power of two, minimum 4. Index width AW = clog2(NREGS) is derived internally.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return stored array contents only.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- reg_write  in  1  write enable for the current cycle.
- write_reg  in  AW  destination register index.
- write_data  in  XLEN  data to write.
- read_reg1  in  AW  read port 1 index.
- read_reg2  in  AW  read port 2 index.
- read_data1  out  XLEN  read port 1 data (combinational).
- read_data2  out  XLEN  read port 2 data (combinational).
- issue_valid  in  1  an instruction writing issue_rd is being issued this cycle.
- issue_rd  in  AW  destination register of the issued instruction.
- rs_busy1  out  1  register read_reg1 has a pending producer (combinational).
- rs_busy2  out  1  register read_reg2 has a pending producer (combinational).
- clear_req  in  1  one-cycle pulse that starts a scrub of the array.
- clear_busy  out  1  high while the scrub is in progress (registered).

Behaviour:
Reset:
- Asserting reset clears all registers and all busy bits to 0 immediately (asynchronously).
- The FSM goes to IDLE, the scrub counter goes to 0, and clear_busy goes to 0.
- Read outputs follow from the cleared state: read_data = 0, rs_busy = 0.

Reads:
- Reads are combinational.
- Index 0 always returns 0 and rs_busy = 0 for index 0.
- Bypass applies only when BYPASS=1, the FSM is in IDLE, reg_write=1, write_reg == read_regN and write_reg != 0. In that case read_dataN = write_data and rs_busyN = 0.
- In all other cases read_dataN = stored value and rs_busyN = busy[read_regN].

Writes:
- A write occurs on the rising edge when reg_write=1, the FSM is in IDLE and write_reg != 0. It writes write_data into regs[write_reg] and clears busy[write_reg].
- Writes to index 0 are dropped.
- Write latency is one cycle: the stored value is visible the cycle after the write without bypass, and in the same cycle with bypass.

Scoreboard:
- On the rising edge, issue_valid=1 with issue_rd != 0 sets busy[issue_rd], but only when the FSM is in IDLE.
- If the issue and a write target the same index in the same cycle, the set wins. The newly issued producer is still pending, so busy[idx] = 1 after the edge.
- If the issue and a write target different indices, both take effect.

Clear FSM (states IDLE, CLEAR):
- IDLE to CLEAR: clear_req=1 on a rising edge. The counter loads 1 and clear_busy goes to 1 on that edge.
- In CLEAR, each cycle:
  - regs[cnt] is set to 0 and busy[cnt] is set to 0.
  - cnt increments by 1.
  - When cnt == NREGS-1 the final register is cleared and the FSM returns to IDLE. clear_busy falls on that same edge.
- The scrub therefore lasts exactly NREGS-1 cycles; clear_busy is high for NREGS-1 cycles.
- While in CLEAR:
  - reg_write and issue_valid are ignored; their write and issue are lost, so the pipeline must stall.
  - rs_busy1 and rs_busy2 are forced to 1.
  - Reads return the partially cleared array contents with no bypass.
  - clear_req is ignored; the scrub does not restart.
- Reset asserted mid-scrub aborts it immediately: the FSM goes to IDLE and all state is zero.
- The counter is AW bits wide. It cannot wrap because the exit occurs at NREGS-1.

Test Plan:
- Reset, then write 0xDEADBEEF to x5. In the same cycle read_reg1=5 -> read_data1=0xDEADBEEF (BYPASS=1). Next cycle with reg_write=0 -> read_data1=0xDEADBEEF. Repeat with BYPASS=0 -> read_data1 is 0 in the write cycle and 0xDEADBEEF the next cycle.
- Write 0x12345678 to x0, then read x0 on both ports -> read_data1 = read_data2 = 0 and rs_busy = 0.
- Issue rd=7, then read_reg2=7 -> rs_busy2=1. Write x7=0xA5 -> rs_busy2=0 in the write cycle (bypass) and remains 0 afterwards.
- Same cycle: issue_rd=9 and write_reg=9 with data 0x55 -> after the edge regs[9]=0x55 and busy[9]=1. Same cycle: issue_rd=3 and write_reg=4 -> busy[3]=1 and busy[4]=0.
- Fill x1..x31 with their own index and mark x10 busy. Pulse clear_req -> clear_busy is high for exactly 31 cycles and rs_busy1 = rs_busy2 = 1 throughout. reg_write to x2 during the scrub is dropped. Afterwards all registers read 0 and all busy bits are 0.
- Start a scrub and assert reset after 10 cycles -> clear_busy=0 immediately, all registers read 0, and the next write to x1 succeeds.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the register-file read/write, issue and scrub signals.
// The slave side is the register file; the master side is the pipeline.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            reg_write;
  logic [AW-1:0]   write_reg;
  logic [XLEN-1:0] write_data;
  logic [AW-1:0]   read_reg1;
  logic [AW-1:0]   read_reg2;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            rs_busy1;
  logic            rs_busy2;
  logic            clear_req;
  logic            clear_busy;

  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2,
    output issue_valid, issue_rd, clear_req,
    input  read_data1, read_data2, rs_busy1, rs_busy2, clear_busy
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2,
    input  issue_valid, issue_rd, clear_req,
    output read_data1, read_data2, rs_busy1, rs_busy2, clear_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with optional write bypass, a per-register busy
// scoreboard and a sequential scrub engine that zeroes the array without reset.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam bit BypassEn = (BYPASS != 0);
  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic              hit1, hit2;

  // State register and scrub counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scrub walks indices 1..NREGS-1; index 0 is never stored, so it is skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == LastIdx) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Issue is applied after the write so a same-index issue leaves the register busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (state_q == IDLE) begin
      if (bus.reg_write && (bus.write_reg != '0)) begin
        regs_q[bus.write_reg] <= bus.write_data;
        busy_q[bus.write_reg] <= 1'b0;
      end
      if (bus.issue_valid && (bus.issue_rd != '0)) begin
        busy_q[bus.issue_rd] <= 1'b1;
      end
    end else begin
      regs_q[cnt_q] <= '0;
      busy_q[cnt_q] <= 1'b0;
    end
  end

  assign hit1 = BypassEn && (state_q == IDLE) && bus.reg_write &&
                (bus.write_reg == bus.read_reg1) && (bus.write_reg != '0);
  assign hit2 = BypassEn && (state_q == IDLE) && bus.reg_write &&
                (bus.write_reg == bus.read_reg2) && (bus.write_reg != '0);

  assign bus.read_data1 = (bus.read_reg1 == '0) ? '0 :
                          hit1 ? bus.write_data : regs_q[bus.read_reg1];
  assign bus.read_data2 = (bus.read_reg2 == '0) ? '0 :
                          hit2 ? bus.write_data : regs_q[bus.read_reg2];

  // During a scrub every operand reports busy so the pipeline stalls.
  assign bus.rs_busy1 = (state_q == CLEAR) ? 1'b1 :
                        ((bus.read_reg1 == '0) || hit1) ? 1'b0 : busy_q[bus.read_reg1];
  assign bus.rs_busy2 = (state_q == CLEAR) ? 1'b1 :
                        ((bus.read_reg2 == '0) || hit2) ? 1'b0 : busy_q[bus.read_reg2];

  assign bus.clear_busy = (state_q == CLEAR);
endmodule
